otter_mem_arbiter: RTL and testbench
====================================

// Module: otter_mem_arbiter
// PURPOSE
//  Shares the OTTER memory data port (ADDR2 side) between the CPU load/store unit and the
//  LCD framebuffer DMA reader. Sequences each access: one-cycle writes, two-cycle reads.
//  For the whole return cycle it holds address/size/sign steady, because sized read data is
//  formed combinationally from the live ADDR2/SIZE/SIGN. Sits between CPU/DMA and Memory.
// PARAMETERS
//  BURST_LEN  8  max back-to-back DMA grants while CPU waits (only with OTTER_ARB_DMA_BURST_EN)
// PORTS
//  CLK         in   1   system clock, all state on rising edge
//  RST_N       in   1   asynchronous, active-low reset
//  CPU_REQ     in   1   CPU access request; held with command until CPU_GNT=1
//  CPU_WE      in   1   1=store, 0=load
//  CPU_ADDR    in   32  byte address
//  CPU_DIN     in   32  store data
//  CPU_SIZE    in   2   0=byte 1=half 2=word
//  CPU_SIGN    in   1   1=unsigned 0=signed
//  CPU_GNT     out  1   request accepted this cycle
//  CPU_RVALID  out  1   load data valid on CPU_RDATA
//  CPU_RDATA   out  32  load data
//  DMA_REQ     in   1   DMA word-read request; held with DMA_ADDR until DMA_GNT=1
//  DMA_ADDR    in   32  byte address, word aligned
//  DMA_GNT     out  1   request accepted this cycle
//  DMA_RVALID  out  1   read data valid on DMA_RDATA
//  DMA_RDATA   out  32  read data
//  MEM_RDEN2   out  1   to Memory data read enable
//  MEM_WE2     out  1   to Memory write enable
//  MEM_ADDR2   out  32  to Memory data address
//  MEM_DIN2    out  32  to Memory write data
//  MEM_SIZE    out  2   to Memory access size
//  MEM_SIGN    out  1   to Memory sign select
//  MEM_DOUT2   in   32  from Memory sized read data
// BEHAVIOUR
//  - FSM states: IDLE, RD_RET. Registers: state, owner (CPU/DMA), rd_addr/rd_size/rd_sign,
//    last_grant (round-robin pointer), burst counter (macro only).
//  - Reset: state=IDLE, last_grant=DMA (so CPU wins first tie), counters 0. Every output
//    reads 0 in reset and in IDLE with no request.
//  - IDLE: winner selected combinationally. CPU_GNT/DMA_GNT are Mealy outputs, at most one
//    high. MEM_* are muxed from the winner in the same cycle.
//    DMA is driven with SIZE=2, SIGN=0, WE=0, DIN=0.
//  - Winner is a write: MEM_WE2=1, MEM_RDEN2=0. State stays IDLE, so the next grant can
//    issue on the following cycle.
//  - Winner is a read: MEM_RDEN2=1. Capture ADDR/SIZE/SIGN and owner, then go to RD_RET.
//  - RD_RET (exactly 1 cycle): MEM_ADDR2/SIZE/SIGN come from the captured registers;
//    MEM_RDEN2=0, MEM_WE2=0. Owner's RVALID=1 and owner's RDATA=MEM_DOUT2.
//    No grants in RD_RET. Next state is IDLE.
//  - Read latency: data on the cycle after GNT. Throughput: read 2 cycles, write 1 cycle.
//  - RDATA=0 whenever the matching RVALID=0.
//  - Arbitration, one requester: it wins.
//  - Arbitration, both requesting: the requester not equal to last_grant wins (strict
//    alternation). last_grant updates on every grant.
//  - Addresses >=0x10000 pass through unchanged. CPU MMIO loads return IO data with the same
//    timing. DMA must not target MMIO; this is unchecked.
//  - A requester dropping REQ before GNT is legal; no access occurs.
//  - Async reset in RD_RET: the pending read is discarded; RVALID never asserts for it.
// CONFIGURATION
//  OTTER_ARB_DMA_BURST_EN defined:
//   - While both request and DMA holds last_grant, DMA keeps winning until it has BURST_LEN
//     consecutive grants. CPU then gets the next grant.
//   - The counter resets on any CPU grant, or on any IDLE cycle with DMA_REQ=0.
//  Undefined: strict alternation as above; burst counter is not instantiated.
// TESTING
//  - Reset: RST_N=0 mid-traffic -> all outputs 0 asynchronously; first tie after release
//    grants CPU.
//  - CPU sw 0x0000_0100 <- 0xDEADBEEF, then lb signed 0x103 -> GNT, CPU_RVALID 1 cycle
//    later, RDATA=0xFFFFFFDE. MEM_ADDR2=0x103 held in RD_RET.
//  - CPU and DMA REQ continuous, DMA reads 0x2000.. -> grants alternate C,D,C,D.
//    Each read is 2 cycles; no RVALID to the wrong owner.
//  - DMA read in flight while CPU changes CPU_ADDR in RD_RET -> MEM_ADDR2 stays the DMA
//    address; DMA_RDATA is the correct word.
//  - CPU back-to-back stores x3 -> 3 grants in 3 cycles, MEM_WE2 high each cycle.
//  - Macro on, BURST_LEN=4, both REQ -> D,D,D,D,C,D,D,D,D,C.
//    Macro off -> strict alternation.

Source files
------------

// File: rtl/otter_mem_arbiter_if.sv
// otter_mem_arbiter_if: CPU, DMA and memory-side signals of the OTTER ADDR2 data port.
// slave = arbiter view, master = requesters plus memory view.
interface otter_mem_arbiter_if;
  logic        CPU_REQ;
  logic        CPU_WE;
  logic [31:0] CPU_ADDR;
  logic [31:0] CPU_DIN;
  logic [1:0]  CPU_SIZE;
  logic        CPU_SIGN;
  logic        CPU_GNT;
  logic        CPU_RVALID;
  logic [31:0] CPU_RDATA;
  logic        DMA_REQ;
  logic [31:0] DMA_ADDR;
  logic        DMA_GNT;
  logic        DMA_RVALID;
  logic [31:0] DMA_RDATA;
  logic        MEM_RDEN2;
  logic        MEM_WE2;
  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2;

  modport slave (
    input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_DIN, CPU_SIZE, CPU_SIGN,
    output CPU_GNT, CPU_RVALID, CPU_RDATA,
    input  DMA_REQ, DMA_ADDR,
    output DMA_GNT, DMA_RVALID, DMA_RDATA,
    output MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN,
    input  MEM_DOUT2
  );

  modport master (
    output CPU_REQ, CPU_WE, CPU_ADDR, CPU_DIN, CPU_SIZE, CPU_SIGN,
    input  CPU_GNT, CPU_RVALID, CPU_RDATA,
    output DMA_REQ, DMA_ADDR,
    input  DMA_GNT, DMA_RVALID, DMA_RDATA,
    input  MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN,
    output MEM_DOUT2
  );
endinterface

// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: shares the OTTER ADDR2 data port between CPU LSU and LCD DMA.
// Define OTTER_ARB_DMA_BURST_EN to let DMA take up to BURST_LEN grants in a row.
module otter_mem_arbiter #(
  parameter int BURST_LEN = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  otter_mem_arbiter_if.slave bus
);
  typedef enum logic {IDLE, RD_RET} state_t;

  state_t      state;
  logic        owner_dma;
  logic        last_dma;
  logic [31:0] rd_addr;
  logic [1:0]  rd_size;
  logic        rd_sign;
  logic        cpu_win;
  logic        dma_win;
  logic        tie_dma;
  logic        rvalid;
  logic        win_rd;

`ifdef OTTER_ARB_DMA_BURST_EN
  localparam int CW = $clog2(BURST_LEN + 1);
  logic [CW-1:0] burst_cnt;
  logic          burst_ok;
  assign burst_ok = burst_cnt < CW'(BURST_LEN);
  assign tie_dma  = !last_dma || burst_ok;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (cpu_win || !bus.DMA_REQ)
        burst_cnt <= '0;
      else if (dma_win && burst_ok)
        burst_cnt <= burst_cnt + 1'b1;
    end
  end
`else
  assign tie_dma = !last_dma;
`endif

  // Gated by RST_N so the grants also read 0 while reset is held.
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (RST_N && state == IDLE) begin
      if (bus.CPU_REQ && bus.DMA_REQ) begin
        dma_win = tie_dma;
        cpu_win = !tie_dma;
      end else begin
        cpu_win = bus.CPU_REQ;
        dma_win = bus.DMA_REQ;
      end
    end
  end

  assign rvalid = RST_N && state == RD_RET;
  assign win_rd = dma_win || (cpu_win && !bus.CPU_WE);

  always_comb begin
    bus.CPU_GNT    = 1'b0;
    bus.CPU_RVALID = 1'b0;
    bus.CPU_RDATA  = '0;
    bus.DMA_GNT    = 1'b0;
    bus.DMA_RVALID = 1'b0;
    bus.DMA_RDATA  = '0;
    bus.MEM_RDEN2  = 1'b0;
    bus.MEM_WE2    = 1'b0;
    bus.MEM_ADDR2  = '0;
    bus.MEM_DIN2   = '0;
    bus.MEM_SIZE   = '0;
    bus.MEM_SIGN   = 1'b0;
    unique case (1'b1)
      rvalid: begin
        bus.MEM_ADDR2 = rd_addr;
        bus.MEM_SIZE  = rd_size;
        bus.MEM_SIGN  = rd_sign;
        if (owner_dma) begin
          bus.DMA_RVALID = 1'b1;
          bus.DMA_RDATA  = bus.MEM_DOUT2;
        end else begin
          bus.CPU_RVALID = 1'b1;
          bus.CPU_RDATA  = bus.MEM_DOUT2;
        end
      end
      cpu_win: begin
        bus.CPU_GNT   = 1'b1;
        bus.MEM_WE2   = bus.CPU_WE;
        bus.MEM_RDEN2 = !bus.CPU_WE;
        bus.MEM_ADDR2 = bus.CPU_ADDR;
        bus.MEM_DIN2  = bus.CPU_DIN;
        bus.MEM_SIZE  = bus.CPU_SIZE;
        bus.MEM_SIGN  = bus.CPU_SIGN;
      end
      dma_win: begin
        bus.DMA_GNT   = 1'b1;
        bus.MEM_RDEN2 = 1'b1;
        bus.MEM_ADDR2 = bus.DMA_ADDR;
        bus.MEM_SIZE  = 2'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      owner_dma <= 1'b0;
      last_dma  <= 1'b1;
      rd_addr   <= '0;
      rd_size   <= '0;
      rd_sign   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_win || dma_win)
            last_dma <= dma_win;
          if (win_rd) begin
            state     <= RD_RET;
            owner_dma <= dma_win;
            rd_addr   <= dma_win ? bus.DMA_ADDR : bus.CPU_ADDR;
            rd_size   <= dma_win ? 2'd2 : bus.CPU_SIZE;
            rd_sign   <= dma_win ? 1'b0 : bus.CPU_SIGN;
          end
        end
        RD_RET: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb_otter_mem_arbiter: directed plus random traffic checked against a
// transaction-level model of the arbiter and a shadow word memory.
module tb_otter_mem_arbiter;
  localparam int BL = 4;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic mem_init = 1'b1;
  always #5 CLK = ~CLK;

  otter_mem_arbiter_if bus();

  otter_mem_arbiter #(.BURST_LEN(BL)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail = 0;

  logic [31:0] tmem [16];
  logic [31:0] gmem [16];

  int          m_pend = 0;
  logic [31:0] m_pdata, m_paddr;
  logic [1:0]  m_psize;
  logic        m_psign;
  logic        m_last_dma = 1'b1;
  int          m_cnt = 0;
  logic        cpu_granted = 1'b0;
  logic        dma_granted = 1'b0;
  bit          gq [$];

  function automatic logic [31:0] seed(int i);
    return 32'(32'h9E37_79B9 * (i + 1)) ^ 32'h0F0F_3C3C;
  endfunction

  // SIGN: 1 = zero extend, 0 = sign extend
  function automatic logic [31:0] rd_sz(logic [31:0] w, logic [1:0] lo,
                                        logic [1:0] sz, logic sg);
    logic [31:0] s;
    s = w >> {lo, 3'b000};
    case (sz)
      2'd0: return sg ? {24'b0, s[7:0]} : {{24{s[7]}}, s[7:0]};
      2'd1: return sg ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] wr_sz(logic [31:0] old, logic [1:0] lo,
                                        logic [1:0] sz, logic [31:0] d);
    logic [31:0] m;
    case (sz)
      2'd0: m = 32'hFF << {lo, 3'b000};
      2'd1: m = 32'hFFFF << {lo, 3'b000};
      default: m = 32'hFFFF_FFFF;
    endcase
    return (old & ~m) | ((d << {lo, 3'b000}) & m);
  endfunction

  assign bus.MEM_DOUT2 = rd_sz(tmem[bus.MEM_ADDR2[5:2]], bus.MEM_ADDR2[1:0],
                               bus.MEM_SIZE, bus.MEM_SIGN);

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) tmem[i] <= seed(i);
    end else if (bus.MEM_WE2) begin
      tmem[bus.MEM_ADDR2[5:2]] <= wr_sz(tmem[bus.MEM_ADDR2[5:2]],
        bus.MEM_ADDR2[1:0], bus.MEM_SIZE, bus.MEM_DIN2);
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_ctl"}, 64'({bus.CPU_GNT, bus.CPU_RVALID, bus.DMA_GNT,
        bus.DMA_RVALID, bus.MEM_RDEN2, bus.MEM_WE2, bus.MEM_SIZE,
        bus.MEM_SIGN}), 64'd0);
    chk({tag, "_mem"}, {bus.MEM_ADDR2, bus.MEM_DIN2}, 64'd0);
    chk({tag, "_rdata"}, {bus.CPU_RDATA, bus.DMA_RDATA}, 64'd0);
  endtask

  // One cycle of the reference: who should own the port, and what it returns.
  task automatic model();
    logic c, d, cw, dw, tie;
    logic [36:0] ectl;
    c = bus.CPU_REQ;
    d = bus.DMA_REQ;
    cpu_granted = 1'b0;
    dma_granted = 1'b0;
    if (m_pend != 0) begin
      chk("ret_gnt", 64'({bus.CPU_GNT, bus.DMA_GNT}), 64'd0);
      chk("ret_valid", 64'({bus.CPU_RVALID, bus.DMA_RVALID}),
          (m_pend == 1) ? 64'd2 : 64'd1);
      chk("ret_data", {bus.CPU_RDATA, bus.DMA_RDATA},
          (m_pend == 1) ? {m_pdata, 32'h0} : {32'h0, m_pdata});
      chk("ret_mem", 64'({bus.MEM_RDEN2, bus.MEM_WE2, bus.MEM_SIZE,
          bus.MEM_SIGN, bus.MEM_ADDR2}),
          64'({2'b00, m_psize, m_psign, m_paddr}));
      m_pend = 0;
    end else begin
`ifdef OTTER_ARB_DMA_BURST_EN
      tie = !m_last_dma || (m_cnt < BL);
`else
      tie = !m_last_dma;
`endif
      dw = d && (!c || tie);
      cw = c && !dw;
      chk("gnt", 64'({bus.CPU_GNT, bus.DMA_GNT}), 64'({cw, dw}));
      chk("idle_valid", 64'({bus.CPU_RVALID, bus.DMA_RVALID}), 64'd0);
      chk("idle_rdata", {bus.CPU_RDATA, bus.DMA_RDATA}, 64'd0);
      ectl = '0;
      if (cw)
        ectl = {!bus.CPU_WE, bus.CPU_WE, bus.CPU_SIZE, bus.CPU_SIGN, bus.CPU_ADDR};
      else if (dw)
        ectl = {1'b1, 1'b0, 2'd2, 1'b0, bus.DMA_ADDR};
      chk("mem_ctl", 64'({bus.MEM_RDEN2, bus.MEM_WE2, bus.MEM_SIZE,
          bus.MEM_SIGN, bus.MEM_ADDR2}), 64'(ectl));
      if (!cw || bus.CPU_WE)
        chk("mem_din", 64'(bus.MEM_DIN2), cw ? 64'(bus.CPU_DIN) : 64'd0);
      if (cw) begin
        cpu_granted = 1'b1;
        gq.push_back(1'b0);
        m_last_dma = 1'b0;
        m_cnt = 0;
        if (bus.CPU_WE) begin
          gmem[bus.CPU_ADDR[5:2]] = wr_sz(gmem[bus.CPU_ADDR[5:2]],
            bus.CPU_ADDR[1:0], bus.CPU_SIZE, bus.CPU_DIN);
        end else begin
          m_pend = 1;
          m_paddr = bus.CPU_ADDR;
          m_psize = bus.CPU_SIZE;
          m_psign = bus.CPU_SIGN;
          m_pdata = rd_sz(gmem[bus.CPU_ADDR[5:2]], bus.CPU_ADDR[1:0],
                          bus.CPU_SIZE, bus.CPU_SIGN);
        end
      end else if (dw) begin
        dma_granted = 1'b1;
        gq.push_back(1'b1);
        m_last_dma = 1'b1;
        if (m_cnt < BL) m_cnt++;
        m_pend = 2;
        m_paddr = bus.DMA_ADDR;
        m_psize = 2'd2;
        m_psign = 1'b0;
        m_pdata = gmem[bus.DMA_ADDR[5:2]];
      end
      if (!d) m_cnt = 0;
    end
  endtask

  task automatic settle();
    @(negedge CLK);
    model();
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_pend = 0;
    m_last_dma = 1'b1;
    m_cnt = 0;
    cpu_granted = 1'b0;
    dma_granted = 1'b0;
  endtask

  // Called just after a rising edge; requests are left as they are.
  task automatic reset_mid();
    RST_N = 1'b0;
    #1;
    check_zero("rst_async");
    model_reset();
    @(negedge CLK);
    check_zero("rst_hold");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic idle_bus();
    bus.CPU_REQ = 1'b0;
    bus.DMA_REQ = 1'b0;
  endtask

  task automatic drive_random();
    logic [31:0] a;
    logic [1:0] sz;
    if (!bus.CPU_REQ || cpu_granted) begin
      if ($urandom_range(0, 99) < 60) begin
        sz = 2'($urandom_range(0, 2));
        a = 32'h100 + 32'($urandom_range(0, 63));
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
        bus.CPU_REQ = 1'b1;
        bus.CPU_WE = 1'($urandom);
        bus.CPU_ADDR = a;
        bus.CPU_SIZE = sz;
        bus.CPU_SIGN = 1'($urandom);
        bus.CPU_DIN = $urandom;
      end else begin
        bus.CPU_REQ = 1'b0;
        bus.CPU_ADDR = $urandom;
      end
    end else if ($urandom_range(0, 99) < 3) begin
      bus.CPU_REQ = 1'b0;
    end
    if (!bus.DMA_REQ || dma_granted) begin
      bus.DMA_REQ = ($urandom_range(0, 99) < 55);
      bus.DMA_ADDR = 32'h100 + 32'(4 * $urandom_range(0, 15));
    end else if ($urandom_range(0, 99) < 3) begin
      bus.DMA_REQ = 1'b0;
    end
  endtask

  initial begin
    logic [9:0] got_seq, exp_seq;
    logic bump;
    bus.CPU_REQ = 1'b0;
    bus.CPU_WE = 1'b0;
    bus.CPU_ADDR = '0;
    bus.CPU_DIN = '0;
    bus.CPU_SIZE = '0;
    bus.CPU_SIGN = 1'b0;
    bus.DMA_REQ = 1'b0;
    bus.DMA_ADDR = '0;
    for (int i = 0; i < 16; i++) gmem[i] = seed(i);
    #1;
    check_zero("rst0");
    adv();
    adv();
    mem_init = 1'b0;
    RST_N = 1'b1;

    // sw 0x100 <- DEADBEEF, then lb signed 0x103
    bus.CPU_REQ = 1'b1;
    bus.CPU_WE = 1'b1;
    bus.CPU_ADDR = 32'h100;
    bus.CPU_DIN = 32'hDEAD_BEEF;
    bus.CPU_SIZE = 2'd2;
    settle();
    chk("sw_gnt", 64'(bus.CPU_GNT), 64'd1);
    adv();
    bus.CPU_WE = 1'b0;
    bus.CPU_ADDR = 32'h103;
    bus.CPU_SIZE = 2'd0;
    bus.CPU_SIGN = 1'b0;
    settle();
    chk("lb_gnt", 64'(bus.CPU_GNT), 64'd1);
    adv();
    bus.CPU_REQ = 1'b0;
    bus.CPU_ADDR = 32'h13C;
    settle();
    chk("lb_rvalid", 64'(bus.CPU_RVALID), 64'd1);
    chk("lb_data", 64'(bus.CPU_RDATA), 64'hFFFF_FFDE);
    chk("lb_addr", 64'(bus.MEM_ADDR2), 64'h103);
    adv();

    // DMA read while CPU moves its address during the return cycle
    bus.DMA_REQ = 1'b1;
    bus.DMA_ADDR = 32'h108;
    settle();
    adv();
    bus.DMA_REQ = 1'b0;
    bus.CPU_REQ = 1'b1;
    bus.CPU_WE = 1'b0;
    bus.CPU_ADDR = 32'h13C;
    bus.CPU_SIZE = 2'd2;
    settle();
    chk("dma_hold", 64'(bus.MEM_ADDR2), 64'h108);
    chk("dma_data", 64'(bus.DMA_RDATA), 64'(gmem[2]));
    adv();
    settle();
    adv();
    bus.CPU_REQ = 1'b0;
    settle();
    adv();

    // three back-to-back stores
    for (int k = 0; k < 3; k++) begin
      bus.CPU_REQ = 1'b1;
      bus.CPU_WE = 1'b1;
      bus.CPU_ADDR = 32'h110 + 32'(4 * k);
      bus.CPU_DIN = $urandom;
      bus.CPU_SIZE = 2'd2;
      settle();
      chk("st_b2b", 64'({bus.CPU_GNT, bus.MEM_WE2}), 64'd3);
      adv();
    end
    idle_bus();
    settle();
    adv();

    // both requesting continuously from reset
    reset_mid();
    gq.delete();
    bus.CPU_REQ = 1'b1;
    bus.CPU_WE = 1'b0;
    bus.CPU_ADDR = 32'h104;
    bus.CPU_SIZE = 2'd2;
    bus.DMA_REQ = 1'b1;
    bus.DMA_ADDR = 32'h2000;
    for (int n = 0; n < 20; n++) begin
      settle();
      bump = dma_granted;
      adv();
      if (bump) bus.DMA_ADDR = bus.DMA_ADDR + 32'd4;
    end
    chk("alt_cnt", 64'(gq.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      got_seq[i] = (i < gq.size()) ? gq[i] : 1'b0;
`ifdef OTTER_ARB_DMA_BURST_EN
      exp_seq[i] = (i % 5) != 4;
`else
      exp_seq[i] = (i % 2) == 1;
`endif
    end
    chk("alt_seq", 64'(got_seq), 64'(exp_seq));
    idle_bus();
    settle();
    adv();
    settle();
    adv();

    // random traffic with a reset landing mid-stream
    for (int n = 0; n < 1500; n++) begin
      drive_random();
      settle();
      adv();
      if (n == 700) reset_mid();
    end
    idle_bus();
    settle();
    adv();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
